fifo_rd_ctrl: RTL



---
 rtl/fifo_rd_pkg.sv | 14 +
 rtl/skid_buf.sv | 51 +++++
 rtl/fifo_rd_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared state encoding and constants for the FIFO read-side drain controller.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Smallest skid depth that sustains one word per cycle across the read latency.
  localparam int MIN_BUF_DEPTH = 3;

endpackage

// File: rtl/skid_buf.sv
// Small circular buffer absorbing the FIFO read latency; head is zero while empty.
module skid_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [OCC_W-1:0] o_occ
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_occ;
  logic [WIDTH-1:0] r_mem [DEPTH];

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head = (r_occ != '0) ? r_mem[r_rd_ptr] : '0;
  assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side burst drain controller: pops burst_len words and streams them out.
// Optional stall counter output enabled by defining FIFO_RD_CTRL_STATS_EN.
module fifo_rd_ctrl
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int BUF_DEPTH  = 3
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  i_start,
  input  logic [LEN_WIDTH-1:0]  i_burst_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_fifo_rd,
  input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
  input  logic                  i_fifo_empty,
  output logic                  o_out_valid,
  output logic [DATA_WIDTH-1:0] o_out_data,
`ifdef FIFO_RD_CTRL_STATS_EN
  output logic [15:0]           o_stall_cnt,
`endif
  input  logic                  i_out_ready
);

  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam logic [OCC_W:0] DEPTH_C = (OCC_W + 1)'(BUF_DEPTH);

  state_t                r_state;
  state_t                w_state_next;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_issued;
  logic [LEN_WIDTH-1:0]  r_accepted;
  logic [LEN_WIDTH-1:0]  w_accepted_next;
  logic [1:0]            r_pending;
  logic [OCC_W-1:0]      w_occ;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_capture;
  logic                  w_xfer;
  logic                  w_issue;
  logic                  w_start_run;

  // Data from a pop lands on the FIFO port one cycle later and is captured then.
  assign w_capture       = (r_pending != 2'd0);
  assign w_xfer          = o_out_valid && i_out_ready;
  assign w_accepted_next = r_accepted + LEN_WIDTH'(w_xfer);
  assign w_start_run     = (r_state == ST_IDLE) && i_start && (i_burst_len != '0);
  assign w_issue = (r_state == ST_RUN) && !i_fifo_empty && (r_issued < r_len) &&
                   (((OCC_W + 1)'(w_occ) + (OCC_W + 1)'(r_pending)) < DEPTH_C);

  always_ff @(posedge rd_clk) begin
    if (rd_rst) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_state_next = (i_burst_len != '0) ? ST_RUN : ST_DONE;
      ST_RUN:   if (w_issue && (r_issued + 1'b1 == r_len)) w_state_next = ST_DRAIN;
      ST_DRAIN: if (w_accepted_next == r_len) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy    = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    o_done    = (r_state == ST_DONE);
    o_fifo_rd = w_issue;
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_len      <= '0;
      r_issued   <= '0;
      r_accepted <= '0;
      r_pending  <= '0;
    end else begin
      if (w_start_run) begin
        r_len      <= i_burst_len;
        r_issued   <= '0;
        r_accepted <= '0;
      end else begin
        if (w_issue) r_issued <= r_issued + 1'b1;
        if (w_xfer)  r_accepted <= w_accepted_next;
      end
      r_pending <= r_pending + {1'b0, w_issue} - {1'b0, w_capture};
    end
  end

  skid_buf #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_skid (
    .clk         (rd_clk),
    .srst        (rd_rst),
    .i_push      (w_capture),
    .i_push_data (i_fifo_rd_data),
    .i_pop       (w_xfer),
    .o_head      (w_head),
    .o_occ       (w_occ)
  );

  assign o_out_valid = (w_occ != '0);
  assign o_out_data  = w_head;

`ifdef FIFO_RD_CTRL_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge rd_clk) begin
    if (rd_rst || w_start_run) begin
      r_stall_cnt <= '0;
    end else if ((r_state == ST_RUN) && (r_issued < r_len) && i_fifo_empty &&
                 (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule
